// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the block-RAM data-port arbiter.
package mem_arb_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] LOCK0 = 2'd1;
   localparam logic [1:0] LOCK1 = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_LOCK0 = LOCK0,
      ST_LOCK1 = LOCK1
   } arb_state_t;

   localparam logic REQ_CPU = 1'b0;
   localparam logic REQ_IO  = 1'b1;

   localparam int DEF_WIDTH         = 16;
   localparam int DEF_RAM_ADDR_BITS = 16;

   // Requester id that owns the lock in a LOCK state.
   function automatic logic lock_owner(arb_state_t s);
      return (s == ST_LOCK1) ? REQ_IO : REQ_CPU;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshakes plus RAM data-port bus of the arbiter.
interface mem_port_arbiter_if import mem_arb_pkg::*; #(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS
) ();
   logic                     req0, req1;
   logic                     we0, we1;
   logic                     lock0, lock1;
   logic [RAM_ADDR_BITS-1:0] adr0, adr1;
   logic [WIDTH-1:0]         wdata0, wdata1;
   logic                     ack0, ack1;
   logic                     rvalid0, rvalid1;
   logic [WIDTH-1:0]         rdata;
   logic                     mem_en, mem_write, mem_read;
   logic [RAM_ADDR_BITS-1:0] mem_adr;
   logic [WIDTH-1:0]         mem_wdata;
   logic [WIDTH-1:0]         mem_rdata;
   logic                     lock_err;

   modport master (
      output req0, req1, we0, we1, lock0, lock1, adr0, adr1, wdata0, wdata1, mem_rdata,
      input  ack0, ack1, rvalid0, rvalid1, rdata, mem_en, mem_write, mem_read,
             mem_adr, mem_wdata, lock_err
   );

   modport slave (
      input  req0, req1, we0, we1, lock0, lock1, adr0, adr1, wdata0, wdata1, mem_rdata,
      output ack0, ack1, rvalid0, rvalid1, rdata, mem_en, mem_write, mem_read,
             mem_adr, mem_wdata, lock_err
   );
endinterface

// File: rtl/mem_arb_rr.sv
// Two-way grant logic with last-winner pointer.
// MEM_PORT_ARB_FIXED_PRIO_EN: requester 0 always wins in IDLE; pointer removed.
module mem_arb_rr import mem_arb_pkg::*; (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req0,
   input  logic       req1,
   input  arb_state_t state,
   input  logic       upd,
   input  logic       upd_id,
   output logic       ack0,
   output logic       ack1
);
   logic prefer1;

`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
   logic unused_rr;
   assign prefer1   = 1'b0;
   assign unused_rr = ^{clk, reset_n, upd, upd_id};
`else
   logic last_reg;

   // Reset to REQ_IO so the CPU wins the first contested cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         last_reg <= REQ_IO;
      else if (upd)
         last_reg <= upd_id;
   end

   assign prefer1 = (last_reg == REQ_CPU);
`endif

   always_comb begin
      ack0 = 1'b0;
      ack1 = 1'b0;
      case (state)
         ST_LOCK0: ack0 = req0;
         ST_LOCK1: ack1 = req1;
         default: begin
            if (req0 && req1) begin
               ack0 = !prefer1;
               ack1 = prefer1;
            end else begin
               ack0 = req0;
               ack1 = req1;
            end
         end
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the block-RAM data port between CPU (0) and game I/O (1): arbitration,
// lock with timeout, registered issue, read-source tracking. Macro: MEM_PORT_ARB_FIXED_PRIO_EN.
module mem_port_arbiter import mem_arb_pkg::*; #(
   parameter int WIDTH         = DEF_WIDTH,
   parameter int RAM_ADDR_BITS = DEF_RAM_ADDR_BITS,
   parameter int MAX_LOCK      = 16
) (
   input logic               clk,
   input logic               reset_n,
   mem_port_arbiter_if.slave bus
);
   // The counter starts at 0 on entry, so MAX_LOCK-2 is the last cycle a lock may live.
   localparam logic [7:0] TIMEOUT_CNT = 8'(MAX_LOCK - 2);

   arb_state_t               state_reg, state_next;
   logic [7:0]               cnt_reg, cnt_next;
   logic                     lock_err_reg, lock_err_next;
   logic                     ack0, ack1;
   logic                     xfer, win, owner, upd, upd_id;
   logic                     sel_we, sel_lock;
   logic [RAM_ADDR_BITS-1:0] sel_adr;
   logic [WIDTH-1:0]         sel_wdata;
   logic                     mem_en_reg, mem_write_reg, mem_read_reg;
   logic [RAM_ADDR_BITS-1:0] mem_adr_reg;
   logic [WIDTH-1:0]         mem_wdata_reg;
   logic                     rd_v1_reg, rd_id1_reg, rd_v2_reg, rd_id2_reg;

   mem_arb_rr u_rr (
      .clk     (clk),
      .reset_n (reset_n),
      .req0    (bus.req0),
      .req1    (bus.req1),
      .state   (state_reg),
      .upd     (upd),
      .upd_id  (upd_id),
      .ack0    (ack0),
      .ack1    (ack1)
   );

   assign xfer      = (bus.req0 & ack0) | (bus.req1 & ack1);
   assign win       = bus.req1 & ack1;
   assign owner     = lock_owner(state_reg);
   assign sel_we    = win ? bus.we1    : bus.we0;
   assign sel_lock  = win ? bus.lock1  : bus.lock0;
   assign sel_adr   = win ? bus.adr1   : bus.adr0;
   assign sel_wdata = win ? bus.wdata1 : bus.wdata0;

   always_comb begin
      state_next    = state_reg;
      cnt_next      = cnt_reg;
      lock_err_next = lock_err_reg;
      upd           = xfer;
      upd_id        = win;
      case (state_reg)
         ST_IDLE: begin
            if (xfer && sel_lock) begin
               state_next = win ? ST_LOCK1 : ST_LOCK0;
               cnt_next   = 8'd0;
            end
         end
         ST_LOCK0, ST_LOCK1: begin
            cnt_next = cnt_reg + 8'd1;
            if (xfer && !sel_lock) begin
               state_next = ST_IDLE;
            end else if (cnt_reg == TIMEOUT_CNT) begin
               // Forced release; a locked transfer in this cycle still goes out.
               state_next    = ST_IDLE;
               lock_err_next = 1'b1;
               upd           = 1'b1;
               upd_id        = owner;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         cnt_reg      <= 8'd0;
         lock_err_reg <= 1'b0;
      end else begin
         state_reg    <= state_next;
         cnt_reg      <= cnt_next;
         lock_err_reg <= lock_err_next;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_en_reg    <= 1'b0;
         mem_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_adr_reg   <= '0;
         mem_wdata_reg <= '0;
      end else begin
         mem_en_reg    <= xfer;
         mem_write_reg <= xfer & sel_we;
         mem_read_reg  <= xfer & ~sel_we;
         if (xfer) begin
            mem_adr_reg   <= sel_adr;
            mem_wdata_reg <= sel_wdata;
         end
      end
   end

   // Read-source pipeline: stage 2 lines up with the RAM's registered read data.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_v1_reg  <= 1'b0;
         rd_id1_reg <= REQ_CPU;
         rd_v2_reg  <= 1'b0;
         rd_id2_reg <= REQ_CPU;
      end else begin
         rd_v1_reg  <= xfer & ~sel_we;
         rd_id1_reg <= win;
         rd_v2_reg  <= rd_v1_reg;
         rd_id2_reg <= rd_id1_reg;
      end
   end

   assign bus.ack0      = ack0;
   assign bus.ack1      = ack1;
   assign bus.rvalid0   = rd_v2_reg & (rd_id2_reg == REQ_CPU);
   assign bus.rvalid1   = rd_v2_reg & (rd_id2_reg == REQ_IO);
   assign bus.rdata     = bus.mem_rdata;
   assign bus.mem_en    = mem_en_reg;
   assign bus.mem_write = mem_write_reg;
   assign bus.mem_read  = mem_read_reg;
   assign bus.mem_adr   = mem_adr_reg;
   assign bus.mem_wdata = mem_wdata_reg;
   assign bus.lock_err  = lock_err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: registered-read RAM model plus
// per-requester read scoreboards; honours MEM_PORT_ARB_FIXED_PRIO_EN.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int W  = 16;
   localparam int A  = 16;
   localparam int ML = 16;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter_if #(.WIDTH(W), .RAM_ADDR_BITS(A)) bus ();

   mem_port_arbiter #(.WIDTH(W), .RAM_ADDR_BITS(A), .MAX_LOCK(ML)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   typedef struct {
      logic [W-1:0] data;
      int           due;
   } rd_exp_t;

   int           n_checks = 0;
   int           n_pass   = 0;
   int           cyc      = 0;
   rd_exp_t      q0[$];
   rd_exp_t      q1[$];
   logic [W-1:0] ram_model[int];
   logic [W-1:0] exp_mem[int];
   logic [W-1:0] mem_rdata_r = '0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [W-1:0] ram_init(int a);
      case (a)
         'h10:    return 16'h1234;
         'h01:    return 16'h1111;
         'h02:    return 16'h2222;
         default: return W'(a) ^ 16'h5A5A;
      endcase
   endfunction

   function automatic logic [W-1:0] ram_peek(int a);
      return ram_model.exists(a) ? ram_model[a] : ram_init(a);
   endfunction

   function automatic logic [W-1:0] exp_peek(int a);
      return exp_mem.exists(a) ? exp_mem[a] : ram_init(a);
   endfunction

   // Block RAM with registered read, read-before-write.
   always @(posedge clk) begin
      if (bus.mem_en) begin
         if (bus.mem_read) mem_rdata_r <= ram_peek(int'(bus.mem_adr));
         if (bus.mem_write) ram_model[int'(bus.mem_adr)] = bus.mem_wdata;
      end
   end
   assign bus.mem_rdata = mem_rdata_r;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: handshake recording, read-return scoreboard, ack sanity.
   always @(negedge clk) begin : monitor
      logic    exp_rv;
      rd_exp_t e;
      if (!reset_n) begin
         q0.delete();
         q1.delete();
         check("rst_rvalid0", 32'(bus.rvalid0), 32'd0);
         check("rst_rvalid1", 32'(bus.rvalid1), 32'd0);
      end else begin
         check("ack_excl", 32'(bus.ack0 & bus.ack1), 32'd0);
         check("ack0_noreq", 32'(bus.ack0 & ~bus.req0), 32'd0);
         check("ack1_noreq", 32'(bus.ack1 & ~bus.req1), 32'd0);

         exp_rv = (q0.size() > 0) && (q0[0].due == cyc);
         check("rvalid0", 32'(bus.rvalid0), 32'(exp_rv));
         if (exp_rv && bus.rvalid0) begin
            e = q0.pop_front();
            check("rdata0", 32'(bus.rdata), 32'(e.data));
            $display("rd ret r0 data=0x%04h cycle %0d", bus.rdata, cyc);
         end
         exp_rv = (q1.size() > 0) && (q1[0].due == cyc);
         check("rvalid1", 32'(bus.rvalid1), 32'(exp_rv));
         if (exp_rv && bus.rvalid1) begin
            e = q1.pop_front();
            check("rdata1", 32'(bus.rdata), 32'(e.data));
            $display("rd ret r1 data=0x%04h cycle %0d", bus.rdata, cyc);
         end

         if (bus.req0 && bus.ack0) begin
            if (bus.we0) exp_mem[int'(bus.adr0)] = bus.wdata0;
            else q0.push_back('{data: exp_peek(int'(bus.adr0)), due: cyc + 2});
            $display("xfer r0 we=%0d lock=%0d adr=0x%04h wdata=0x%04h cycle %0d",
                     bus.we0, bus.lock0, bus.adr0, bus.wdata0, cyc);
         end
         if (bus.req1 && bus.ack1) begin
            if (bus.we1) exp_mem[int'(bus.adr1)] = bus.wdata1;
            else q1.push_back('{data: exp_peek(int'(bus.adr1)), due: cyc + 2});
            $display("xfer r1 we=%0d lock=%0d adr=0x%04h wdata=0x%04h cycle %0d",
                     bus.we1, bus.lock1, bus.adr1, bus.wdata1, cyc);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      logic exp0, got0, got1;
      int   n0, n1;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.lock0 = 1'b0; bus.adr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.lock1 = 1'b0; bus.adr1 = '0; bus.wdata1 = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_en", 32'(bus.mem_en), 32'd0);
      check("rst_mem_write", 32'(bus.mem_write), 32'd0);
      check("rst_mem_read", 32'(bus.mem_read), 32'd0);
      check("rst_mem_adr", 32'(bus.mem_adr), 32'd0);
      check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
      check("rst_lock_err", 32'(bus.lock_err), 32'd0);
      step();
      reset_n = 1'b1;

      // Single CPU read of 0x0010
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 16'h0010;
      @(negedge clk);
      check("t1_ack0", 32'(bus.ack0), 32'd1);
      check("t1_ack1", 32'(bus.ack1), 32'd0);
      step();
      bus.req0 = 1'b0;
      @(negedge clk);
      check("t1_mem_en", 32'(bus.mem_en), 32'd1);
      check("t1_mem_read", 32'(bus.mem_read), 32'd1);
      check("t1_mem_write", 32'(bus.mem_write), 32'd0);
      check("t1_mem_adr", 32'(bus.mem_adr), 32'h0010);
      step();
      @(negedge clk);
      check("t1_mem_en_off", 32'(bus.mem_en), 32'd0);
      check("t1_rdata", 32'(bus.rdata), 32'h1234);
      step();

      // Both requesters writing continuously; CPU won last, so I/O goes first
      n0 = 0; n1 = 0;
      bus.req0 = 1'b1; bus.we0 = 1'b1; bus.adr0 = 16'h0030; bus.wdata0 = 16'hAAAA;
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.adr1 = 16'h0030; bus.wdata1 = 16'h5555;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
         exp0 = 1'b1;
`else
         exp0 = (k % 2 == 1);
`endif
         check("t2_ack0", 32'(bus.ack0), 32'(exp0));
         check("t2_ack1", 32'(bus.ack1), 32'(!exp0));
         if (k > 0) check("t2_mem_en", 32'(bus.mem_en), 32'd1);
         got0 = bus.ack0;
         got1 = bus.ack1;
         step();
         if (got0) begin n0++; bus.adr0 = A'(16'h0030 + n0); end
         if (got1) begin n1++; bus.adr1 = A'(16'h0030 + n1); end
      end
      bus.req1 = 1'b0;
      bus.we0  = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.adr0 = A'(16'h0030 + k);
         @(negedge clk);
         check("t2_rb_ack0", 32'(bus.ack0), 32'd1);
         step();
      end
      bus.req0 = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 4; k++)
         check("t2_ram", 32'(ram_peek('h30 + k)), 32'hAAAA);

      // I/O locked read-modify-write; CPU must wait
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.lock1 = 1'b1; bus.adr1 = 16'h0050;
      @(negedge clk);
      check("t3_ack1_rd", 32'(bus.ack1), 32'd1);
      step();
      bus.req1 = 1'b0; bus.lock1 = 1'b0;
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 16'h0060;
      repeat (2) begin
         @(negedge clk);
         check("t3_ack0_locked", 32'(bus.ack0), 32'd0);
         step();
      end
      bus.req1 = 1'b1; bus.we1 = 1'b1; bus.lock1 = 1'b0; bus.adr1 = 16'h0051; bus.wdata1 = 16'hBEEF;
      @(negedge clk);
      check("t3_ack1_wr", 32'(bus.ack1), 32'd1);
      check("t3_ack0_wr", 32'(bus.ack0), 32'd0);
      step();
      bus.req1 = 1'b0;
      @(negedge clk);
      check("t3_ack0_after", 32'(bus.ack0), 32'd1);
      check("t3_lock_err", 32'(bus.lock_err), 32'd0);
      step();
      bus.req0 = 1'b0;

      // CPU lock timeout: released MAX_LOCK-1 cycles after entry
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.lock0 = 1'b1; bus.adr0 = 16'h0070;
      @(negedge clk);
      check("t4_ack0", 32'(bus.ack0), 32'd1);
      step();
      bus.req0 = 1'b0; bus.lock0 = 1'b0;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 16'h0071;
      for (int k = 1; k < ML; k++) begin
         @(negedge clk);
         check("t4_ack1_blocked", 32'(bus.ack1), 32'd0);
         check("t4_err_low", 32'(bus.lock_err), 32'd0);
         step();
      end
      @(negedge clk);
      check("t4_ack1_release", 32'(bus.ack1), 32'd1);
      check("t4_lock_err", 32'(bus.lock_err), 32'd1);
      step();
      bus.req1 = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("t4_err_sticky", 32'(bus.lock_err), 32'd1);
         step();
      end

      // Reset while a read is in flight
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 16'h0010;
      @(negedge clk);
      check("t5_ack0", 32'(bus.ack0), 32'd1);
      step();
      bus.req0 = 1'b0;
      reset_n  = 1'b0;
      @(negedge clk);
      check("t5_mem_en", 32'(bus.mem_en), 32'd0);
      check("t5_mem_read", 32'(bus.mem_read), 32'd0);
      check("t5_mem_adr", 32'(bus.mem_adr), 32'd0);
      check("t5_rvalid0", 32'(bus.rvalid0), 32'd0);
      check("t5_lock_err", 32'(bus.lock_err), 32'd0);
      step();
      step();
      reset_n = 1'b1;
      repeat (4) step();

      // Alternating reads after reset: CPU wins the first contested cycle
      bus.req0 = 1'b1; bus.we0 = 1'b0; bus.adr0 = 16'h0001;
      bus.req1 = 1'b1; bus.we1 = 1'b0; bus.adr1 = 16'h0002;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
`ifdef MEM_PORT_ARB_FIXED_PRIO_EN
         exp0 = 1'b1;
`else
         exp0 = (k % 2 == 0);
`endif
         check("t6_ack0", 32'(bus.ack0), 32'(exp0));
         check("t6_ack1", 32'(bus.ack1), 32'(!exp0));
         step();
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (4) step();

      check("drain_q0", 32'(q0.size()), 32'd0);
      check("drain_q1", 32'(q1.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
